// File: rtl/vt_pkg.sv
// Shared virtual-time definitions used by the time-driven pipeline stages.
package vt_pkg;

  localparam int TIME_SCALE_WIDTH = 32;

  typedef logic [TIME_SCALE_WIDTH-1:0] vt_t;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_HOLD
  } slot_state_t;

  // Modular compare: a timestamp is due once now - ts lands in the lower half of the ring.
  function automatic logic vt_is_due(vt_t now, vt_t ts);
    vt_t diff;
    diff = now - ts;
    return ~diff[TIME_SCALE_WIDTH-1];
  endfunction

endpackage

// File: rtl/vt_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flush.
module vt_sync_fifo
  import vt_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/vt_event_scheduler.sv
// Buffers timestamped events and releases each one into a registered output
// slot once the virtual clock reaches its timestamp; counts late releases.
module vt_event_scheduler #(
  parameter int TIME_SCALE_WIDTH = vt_pkg::TIME_SCALE_WIDTH,
  parameter int DATA_WIDTH       = 32,
  parameter int DEPTH            = 8,
  parameter int LATE_CNT_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [TIME_SCALE_WIDTH-1:0] virtual_time,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [TIME_SCALE_WIDTH-1:0] in_ts,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [TIME_SCALE_WIDTH-1:0] out_ts,
  output logic                        out_late,
  input  logic                        flush,
  output logic [LATE_CNT_WIDTH-1:0]   late_count,
  output logic [$clog2(DEPTH):0]      level
);

  import vt_pkg::*;

  localparam int FW = TIME_SCALE_WIDTH + DATA_WIDTH;

  logic [FW-1:0]               head;
  logic [TIME_SCALE_WIDTH-1:0] head_ts;
  logic [DATA_WIDTH-1:0]       head_data;
  logic [TIME_SCALE_WIDTH-1:0] diff;
  logic                        full;
  logic                        empty;
  logic                        push;
  logic                        due;
  logic                        slot_free;
  logic                        load;
  slot_state_t                 state;

  assign in_ready  = ~full;
  assign push      = in_valid & ~full & ~flush;
  assign {head_ts, head_data} = head;
  assign diff      = virtual_time - head_ts;
  assign due       = ~diff[TIME_SCALE_WIDTH-1];
  assign slot_free = (state == SLOT_EMPTY) | out_ready;
  assign load      = ~empty & due & slot_free & ~flush;

  vt_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (load),
    .wdata ({in_ts, in_data}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // A due head is loaded whenever the slot is empty or being drained this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SLOT_EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ts     <= '0;
      out_late   <= 1'b0;
      late_count <= '0;
    end else if (flush) begin
      state      <= SLOT_EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ts     <= '0;
      out_late   <= 1'b0;
      late_count <= '0;
    end else if (load) begin
      state     <= SLOT_HOLD;
      out_valid <= 1'b1;
      out_data  <= head_data;
      out_ts    <= head_ts;
      out_late  <= |diff;
      if ((|diff) && !(&late_count)) late_count <= late_count + LATE_CNT_WIDTH'(1);
    end else if (state == SLOT_HOLD && out_ready) begin
      state     <= SLOT_EMPTY;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vt_event_scheduler.sv
// Directed scoreboard bench for vt_event_scheduler: timing, lateness, burst, flush, wrap, async reset.
module tb_vt_event_scheduler;

  typedef struct {
    logic [31:0] ts;
    logic [31:0] data;
    logic        late;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] vt;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ts;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_ts;
  logic        out_late;
  logic        flush;
  logic [15:0] late_count;
  logic [3:0]  level;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  vt_event_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .virtual_time (vt),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ts        (in_ts),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ts       (out_ts),
    .out_late     (out_late),
    .flush        (flush),
    .late_count   (late_count),
    .level        (level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    vt = vt + 32'd1;
  endtask

  task automatic advanceTo(input logic [31:0] target);
    for (int k = 0; k < 300 && vt != target; k++) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkRelease(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s observed=scoreboard_empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      checkOutput({tag, "_data"}, out_data, e.data);
      checkOutput({tag, "_ts"}, out_ts, e.ts);
      checkOutput({tag, "_late"}, {31'd0, out_late}, {31'd0, e.late});
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ts, input logic [31:0] data, input logic late);
    exp_t e;
    checkOutput("push_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_ts    = ts;
    in_data  = data;
    e.ts = ts;
    e.data = data;
    e.late = late;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b1;
    vt        = 32'd0;
    in_valid  = 1'b0;
    in_ts     = 32'd0;
    in_data   = 32'd0;
    out_ready = 1'b1;
    flush     = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_ts", out_ts, 32'd0);
    checkOutput("rst_out_late", {31'd0, out_late}, 32'd0);
    checkOutput("rst_late_count", {16'd0, late_count}, 32'd0);
    checkOutput("rst_level", {28'd0, level}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    vt = 32'd0;

    // On-time release: ts=10 pushed at time 2 appears the cycle after time 10.
    tick();
    tick();
    applyStimulus(32'd10, 32'hA, 1'b0);
    checkOutput("t1_level", {28'd0, level}, 32'd1);
    advanceTo(32'd10);
    checkOutput("t1_not_yet", {31'd0, out_valid}, 32'd0);
    tick();
    checkRelease("t1");
    tick();
    checkOutput("t1_drained", {31'd0, out_valid}, 32'd0);

    // Late event: accepted at time 20 with ts=5, visible two cycles later.
    advanceTo(32'd20);
    applyStimulus(32'd5, 32'hB, 1'b1);
    checkOutput("t2_n1", {31'd0, out_valid}, 32'd0);
    tick();
    checkRelease("t2");
    checkOutput("t2_late_count", {16'd0, late_count}, 32'd1);
    tick();
    checkOutput("t2_drained", {31'd0, out_valid}, 32'd0);

    // Fill the buffer, hold the consumer off, then drain back to back.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(32'd100 + i, 32'h300 + i, i != 0);
    checkOutput("t3_full_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("t3_full_level", {28'd0, level}, 32'd8);
    advanceTo(32'd100);
    checkOutput("t3_pre", {31'd0, out_valid}, 32'd0);
    tick();
    checkOutput("t3_loaded_level", {28'd0, level}, 32'd7);
    advanceTo(32'd110);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkRelease("t3_burst");
      tick();
    end
    checkOutput("t3_done_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t3_late_count", {16'd0, late_count}, 32'd8);
    checkOutput("t3_done_level", {28'd0, level}, 32'd0);

    // Flush with four buffered events and the slot holding one.
    out_ready = 1'b0;
    begin
      logic [31:0] base;
      base = vt;
      for (int i = 0; i < 5; i++) applyStimulus(base + 32'd3, 32'h400 + i, 1'b0);
    end
    checkOutput("t4_level", {28'd0, level}, 32'd4);
    checkOutput("t4_hold", {31'd0, out_valid}, 32'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_ts    = vt;
    in_data  = 32'hDEAD;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    checkOutput("t4_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t4_level0", {28'd0, level}, 32'd0);
    checkOutput("t4_late_count", {16'd0, late_count}, 32'd0);
    checkOutput("t4_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    checkOutput("t4_discarded", {31'd0, out_valid}, 32'd0);

    // Virtual time wraps before the timestamp becomes due.
    vt = 32'hFFFF_FFFC;
    out_ready = 1'b1;
    applyStimulus(32'd2, 32'hC, 1'b0);
    for (int k = 0; k < 10 && vt != 32'd2; k++) begin
      checkOutput("t5_wrap_wait", {31'd0, out_valid}, 32'd0);
      tick();
    end
    checkOutput("t5_at_ts", {31'd0, out_valid}, 32'd0);
    tick();
    checkRelease("t5");
    tick();

    // Asynchronous reset while an event is presented.
    out_ready = 1'b0;
    applyStimulus(vt, 32'hD, 1'b1);
    tick();
    checkRelease("t6");
    checkOutput("t6_late_count", {16'd0, late_count}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t6_data", out_data, 32'd0);
    checkOutput("t6_ts", out_ts, 32'd0);
    checkOutput("t6_late", {31'd0, out_late}, 32'd0);
    checkOutput("t6_late_count0", {16'd0, late_count}, 32'd0);
    checkOutput("t6_level", {28'd0, level}, 32'd0);
    checkOutput("t6_in_ready", {31'd0, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vt_event_scheduler.md
# vt_event_scheduler

Releases timestamped events when the free-running virtual clock reaches their timestamp. Sits directly downstream of the virtual time counter: takes its `virtual_time` output as the time base, buffers in-order events from a producer via valid/ready, and presents each event on a registered valid/ready output once due. Flags and counts events released after their timestamp.

## Interface
- `TIME_SCALE_WIDTH`, 32: width of virtual time and timestamps
- `DATA_WIDTH`, 32: event payload width
- `DEPTH`, 8: event buffer entries; power of two, ≥2
- `LATE_CNT_WIDTH`, 16: width of late-event counter

Ports:
- `clk`  in  1  single system clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `virtual_time`  in  TIME_SCALE_WIDTH  current virtual time from the counter stage
- `in_valid`  in  1  event offered
- `in_ready`  out  1  event accepted when `in_valid && in_ready`
- `in_ts`  in  TIME_SCALE_WIDTH  release timestamp
- `in_data`  in  DATA_WIDTH  payload
- `out_valid`  out  1  registered; event presented
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`
- `out_data`  out  DATA_WIDTH  released payload
- `out_ts`  out  TIME_SCALE_WIDTH  its timestamp
- `out_late`  out  1  event loaded with `virtual_time != ts`
- `flush`  in  1  synchronous clear of buffer and output slot
- `late_count`  out  LATE_CNT_WIDTH  saturating count of late releases
- `level`  out  $clog2(DEPTH)+1  buffer occupancy

## Operation
- Buffer: in-order FIFO of {ts, data}. `in_ready = !full`, purely from registered state; no bypass. Push and pop in same cycle allowed at any occupancy except push when full.
- Due test (wrap-aware): `diff = virtual_time - head_ts` mod 2^W; head due when `diff[W-1] == 0`. Timestamps more than 2^(W-1)-1 in the past read as future; producer keeps timestamps within that window.
- Producer issues non-decreasing timestamps (wrap sense). Out-of-order timestamps are not reordered; a later head blocks the ones behind it.
- Output slot states: EMPTY, HOLD.
  - EMPTY → HOLD: buffer non-empty and head due; pop head into slot, `out_late = (diff != 0)`, `late_count` += out_late (saturates at all-ones).
  - HOLD → HOLD with reload: `out_ready` high and head due; consumed event replaced at same edge (back-to-back, one event per cycle).
  - HOLD → EMPTY: `out_ready` high, head not due or buffer empty.
  - HOLD with `out_ready` low: outputs stable.
- `flush`: at the edge, buffer emptied, slot → EMPTY, `late_count` cleared; simultaneous input handshake discarded. Overrides all other events.
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_ts`=0, `out_late`=0, `late_count`=0, `level`=0; buffer pointers zero.

## Timing
- Enqueue-to-visible: accepted event is buffer head earliest one edge after acceptance.
- Release latency: head with ts=T already at head and slot free when `virtual_time`=T in cycle N → `out_valid`=1 in cycle N+1, `out_late`=0.
- Event accepted in cycle N with ts already due → earliest `out_valid` in cycle N+2, `out_late`=1 (unless ts == `virtual_time` at load edge).
- Throughput: one event per cycle when due and consumer ready.
- `level` and `in_ready` update at the edge after push/pop.
- `virtual_time` wrap (all-ones → 0) needs no special handling; modular compare covers it.
- Reset asserted mid-transfer: all state cleared immediately; partially presented event dropped.

## Structure
- Shared package `vt_pkg`: `TIME_SCALE_WIDTH` default constant, `vt_t` time typedef, function `vt_is_due(now, ts)` (modular MSB test) reused by other time-driven stages.
- Sub-module `vt_sync_fifo` (parameterised width/depth, full/empty/level, flush); scheduler top holds due logic, output slot FSM and late counter.

## Test plan
- Reset, `virtual_time` counting from 0; push ts=10,d=0xA at time 2 → `out_valid` rises in cycle after `virtual_time`=10, `out_late`=0, `out_data`=0xA.
- Push ts=5 when `virtual_time`=20 → released 2 cycles after acceptance, `out_late`=1, `late_count`=1.
- Fill DEPTH=8 events ts=100..107, `out_ready` low at 100 → `in_ready`=0, `level`=8; raise `out_ready` → 8 consecutive outputs, one per cycle, data in order.
- Wrap: `virtual_time` starts at 0xFFFF_FFFC, push ts=0x0000_0002 → not released before wrap, released cycle after `virtual_time`=2, `out_late`=0.
- `flush` with 4 buffered and slot HOLD → next cycle `out_valid`=0, `level`=0, `late_count`=0, `in_ready`=1.
- Async `rst_n` low mid-cycle while `out_valid`=1 → outputs return to reset values without waiting for a clock edge.
